// File: rtl/ds18b20_scheduler.sv
// Measurement sequencer in front of the DS18B20 one-wire controller: periodic or
// on-demand conversion starts, done/timeout handling with bounded retry, alarm and error flags.
module ds18b20_scheduler #(
    parameter int PERIOD_CYCLES  = 5_000_000,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4_000_000,
    parameter int MAX_RETRY      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_request,
    input  logic        i_clear,
    input  logic [15:0] i_th_high,
    input  logic [15:0] i_th_low,
    output logic        o_sensor_start,
    input  logic        i_conversion_done,
    input  logic [15:0] i_temperature,
    output logic [15:0] o_temperature,
    output logic        o_valid,
    output logic        o_alarm,
    output logic        o_error,
    output logic        o_busy
);

    localparam int PW   = $clog2(PERIOD_CYCLES);
    localparam int CMAX = (TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES : START_CYCLES;
    localparam int CW   = $clog2(CMAX);

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST   = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] period_cnt;
    logic [CW-1:0] cnt;
    logic [2:0]    retry;
    logic          pending;
    logic          done_d;

    logic tick;
    logic trigger;
    logic done_rise;
    logic timeout;

    logic capture;
    logic cnt_clr;
    logic retry_clr;
    logic retry_inc;
    logic error_set;
    logic pending_clr;

    assign tick      = (period_cnt == PERIOD_LAST) && i_enable;
    assign trigger   = tick | i_request;
    assign done_rise = i_conversion_done & ~done_d;
    // cnt is shared: start-pulse length in START, elapsed wait in WAIT.
    assign timeout   = (cnt == TIMEOUT_LAST);

    assign o_sensor_start = (state == ST_START);
    assign o_busy         = (state != ST_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next  = state;
        capture     = 1'b0;
        cnt_clr     = 1'b0;
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
        error_set   = 1'b0;
        pending_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending || trigger) begin
                    state_next  = ST_START;
                    cnt_clr     = 1'b1;
                    retry_clr   = 1'b1;
                    pending_clr = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == START_LAST) begin
                    state_next = ST_WAIT;
                    cnt_clr    = 1'b1;
                end
            end
            ST_WAIT: begin
                // A done edge coinciding with the timeout is still a capture.
                if (done_rise) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    if (retry < RETRY_LIMIT) begin
                        retry_inc  = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = ST_START;
                    end else begin
                        error_set  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            period_cnt    <= '0;
            cnt           <= '0;
            retry         <= '0;
            pending       <= 1'b0;
            done_d        <= 1'b0;
            o_temperature <= 16'h0000;
            o_valid       <= 1'b0;
            o_alarm       <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            state  <= state_next;
            done_d <= i_conversion_done;

            period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + PW'(1);

            if (cnt_clr)
                cnt <= '0;
            else if (state != ST_IDLE)
                cnt <= cnt + CW'(1);

            if (retry_clr)
                retry <= '0;
            else if (retry_inc)
                retry <= retry + 3'd1;

            // One-deep request latch; the IDLE->START transition consumes it.
            if (pending_clr)
                pending <= 1'b0;
            else if (trigger)
                pending <= 1'b1;

            o_valid <= capture;
            if (capture) begin
                o_temperature <= i_temperature;
                o_alarm       <= ($signed(i_temperature) > $signed(i_th_high)) ||
                                 ($signed(i_temperature) < $signed(i_th_low));
            end

            if (error_set)
                o_error <= 1'b1;
            else if (i_clear)
                o_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ds18b20_scheduler.sv
// Directed bench for ds18b20_scheduler: reset, single capture, alarms, periodic ticks,
// timeout/retry/error, reset during WAIT and merged requests.
module tb_ds18b20_scheduler;

    localparam int PERIOD  = 100;
    localparam int STARTC  = 2;
    localparam int TIMEOUT = 50;
    localparam int RETRIES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        request = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] th_high = 16'h7FFF;
    logic [15:0] th_low = 16'h8000;
    logic        man_done = 1'b0;
    logic [15:0] man_temp = 16'h0000;
    logic        auto_resp = 1'b0;
    logic        resp_done = 1'b0;
    logic        conv_done;
    logic [15:0] temp_in;

    logic        sensor_start;
    logic [15:0] temperature;
    logic        valid;
    logic        alarm;
    logic        error;
    logic        busy;

    assign conv_done = man_done | (auto_resp & resp_done);
    assign temp_in   = auto_resp ? 16'h0100 : man_temp;

    ds18b20_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .START_CYCLES  (STARTC),
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRY     (RETRIES)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (enable),
        .i_request        (request),
        .i_clear          (clear),
        .i_th_high        (th_high),
        .i_th_low         (th_low),
        .o_sensor_start   (sensor_start),
        .i_conversion_done(conv_done),
        .i_temperature    (temp_in),
        .o_temperature    (temperature),
        .o_valid          (valid),
        .o_alarm          (alarm),
        .o_error          (error),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Start-pulse / valid monitor, sampled on the falling edge.
    int cyc = 0;
    int low_run = 0;
    int cur_w = 0;
    int n_valid = 0;
    bit mon_prev = 1'b0;
    int rise_cyc[$];
    int gaps[$];
    int widths[$];

    always @(negedge clk) begin
        cyc++;
        if (sensor_start) begin
            if (!mon_prev) begin
                rise_cyc.push_back(cyc);
                gaps.push_back(low_run);
                cur_w = 0;
            end
            cur_w++;
            low_run = 0;
        end else begin
            if (mon_prev) widths.push_back(cur_w);
            low_run++;
        end
        if (valid) n_valid++;
        mon_prev = sensor_start;
    end

    // Controller model: answers 20 clocks after each start pulse ends.
    int resp_cnt = 0;
    bit resp_prev = 1'b0;
    always @(negedge clk) begin
        if (!auto_resp) begin
            resp_cnt  = 0;
            resp_done = 1'b0;
        end else if (resp_prev && !sensor_start) begin
            resp_cnt  = 20;
            resp_done = 1'b0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            resp_done = (resp_cnt == 0);
        end else begin
            resp_done = 1'b0;
        end
        resp_prev = sensor_start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req();
        request = 1'b1;
        tick();
        request = 1'b0;
    endtask

    // Waits (bounded) for the next start pulse to finish; returns just after the WAIT-entry edge.
    task automatic wait_fall(input string tag);
        int n;
        bit seen;
        n = 0;
        seen = sensor_start;
        while (!(seen && !sensor_start) && n < 400) begin
            tick();
            if (sensor_start) seen = 1'b1;
            n++;
        end
        check(tag, 16'(seen && !sensor_start), 16'h0001);
    endtask

    // Request, answer k clocks into WAIT with temperature t, check the capture pulse.
    task automatic measure(input string tag, input logic [15:0] t, input int k);
        req();
        wait_fall(tag);
        repeat (k) tick();
        man_temp = t;
        man_done = 1'b1;
        tick();
        check(tag, 16'(valid), 16'h0001);
        tick();
        man_done = 1'b0;
    endtask

    int base_r;
    int base_v;
    int n;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_start", 16'(sensor_start), 16'h0000);
        check("rst_temp", temperature, 16'h0000);
        check("rst_valid", 16'(valid), 16'h0000);
        check("rst_alarm", 16'(alarm), 16'h0000);
        check("rst_error", 16'(error), 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        rst = 1'b0;
        tick();

        // First measurement: 2-cycle start pulse, done 10 clocks into WAIT
        base_r = rise_cyc.size();
        base_v = n_valid;
        req();
        check("first_start_c1", 16'(sensor_start), 16'h0001);
        check("first_busy", 16'(busy), 16'h0001);
        tick();
        check("first_start_c2", 16'(sensor_start), 16'h0001);
        tick();
        check("first_start_c3", 16'(sensor_start), 16'h0000);
        check("first_busy_wait", 16'(busy), 16'h0001);
        repeat (9) tick();
        man_temp = 16'h0191;
        man_done = 1'b1;
        tick();
        check("first_valid", 16'(valid), 16'h0001);
        check("first_temp", temperature, 16'h0191);
        check("first_alarm", 16'(alarm), 16'h0000);
        check("first_idle", 16'(busy), 16'h0000);
        tick();
        man_done = 1'b0;
        check("first_valid_once", 16'(valid), 16'h0000);
        repeat (3) tick();
        check("first_pulses", 16'(rise_cyc.size() - base_r), 16'd1);
        check("first_width", 16'(widths[widths.size()-1]), 16'd2);
        check("first_valid_count", 16'(n_valid - base_v), 16'd1);

        // Alarm thresholds: high 400, low -128 (1/16 C)
        th_high = 16'h0190;
        th_low  = 16'hFF80;
        measure("alarm_m1", 16'h0191, 4);
        check("alarm_above_high", 16'(alarm), 16'h0001);
        check("alarm_t1", temperature, 16'h0191);
        measure("alarm_m2", 16'hFF80, 4);
        check("alarm_eq_low", 16'(alarm), 16'h0000);
        check("alarm_t2", temperature, 16'hFF80);
        measure("alarm_m3", 16'hFF7F, 4);
        check("alarm_below_low", 16'(alarm), 16'h0001);
        measure("alarm_m4", 16'h0190, 4);
        check("alarm_eq_high", 16'(alarm), 16'h0000);

        // Periodic ticks answered by the controller model
        base_r = rise_cyc.size();
        base_v = n_valid;
        auto_resp = 1'b1;
        enable = 1'b1;
        repeat (400) tick();
        enable = 1'b0;
        n = 0;
        while ((busy || sensor_start) && n < 200) begin
            tick();
            n++;
        end
        check("per_settled", 16'(busy), 16'h0000);
        repeat (3) tick();
        auto_resp = 1'b0;
        check("per_pulses", 16'(rise_cyc.size() - base_r), 16'd4);
        check("per_spacing", 16'(rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2]), 16'd100);
        check("per_valids", 16'(n_valid - base_v), 16'd4);
        check("per_error", 16'(error), 16'h0000);
        check("per_temp", temperature, 16'h0100);
        check("per_alarm", 16'(alarm), 16'h0000);

        // Timeout: no answer -> 3 attempts then sticky error
        base_r = rise_cyc.size();
        req();
        n = 0;
        while (!error && n < 300) begin
            tick();
            n++;
        end
        check("to_error_set", 16'(error), 16'h0001);
        check("to_idle", 16'(busy), 16'h0000);
        repeat (2) tick();
        check("to_pulses", 16'(rise_cyc.size() - base_r), 16'd3);
        check("to_gap1", 16'(gaps[base_r+1]), 16'd50);
        check("to_gap2", 16'(gaps[base_r+2]), 16'd50);
        check("to_error_sticky", 16'(error), 16'h0001);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("to_clear", 16'(error), 16'h0000);

        // Clear on the very edge that sets the error: set wins
        req();
        wait_fall("setwin_f1");
        wait_fall("setwin_f2");
        wait_fall("setwin_f3");
        repeat (49) tick();
        check("setwin_not_yet", 16'(error), 16'h0000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("setwin_error", 16'(error), 16'h0001);
        check("setwin_idle", 16'(busy), 16'h0000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("setwin_cleared", 16'(error), 16'h0000);

        // Success on the second attempt
        base_r = rise_cyc.size();
        base_v = n_valid;
        req();
        wait_fall("retry_f1");
        wait_fall("retry_f2");
        repeat (5) tick();
        man_temp = 16'h0042;
        man_done = 1'b1;
        tick();
        check("retry_valid", 16'(valid), 16'h0001);
        tick();
        man_done = 1'b0;
        repeat (60) tick();
        check("retry_pulses", 16'(rise_cyc.size() - base_r), 16'd2);
        check("retry_valids", 16'(n_valid - base_v), 16'd1);
        check("retry_error", 16'(error), 16'h0000);
        check("retry_temp", temperature, 16'h0042);

        // Done arriving on the timeout edge wins
        base_r = rise_cyc.size();
        req();
        wait_fall("edge_f1");
        repeat (49) tick();
        man_temp = 16'h0123;
        man_done = 1'b1;
        tick();
        check("edge_valid", 16'(valid), 16'h0001);
        check("edge_idle", 16'(busy), 16'h0000);
        check("edge_temp", temperature, 16'h0123);
        tick();
        man_done = 1'b0;
        repeat (60) tick();
        check("edge_no_retry", 16'(rise_cyc.size() - base_r), 16'd1);

        // Reset during START drops the start pulse at once
        req();
        check("rst_start_pre", 16'(sensor_start), 16'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_start_drop", 16'(sensor_start), 16'h0000);
        check("rst_start_busy", 16'(busy), 16'h0000);

        // Reset during WAIT, then a late done is ignored
        base_v = n_valid;
        req();
        wait_fall("rstw_f1");
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_busy", 16'(busy), 16'h0000);
        check("rstw_temp", temperature, 16'h0000);
        repeat (3) tick();
        man_temp = 16'h0555;
        man_done = 1'b1;
        repeat (3) tick();
        man_done = 1'b0;
        tick();
        check("rstw_no_valid", 16'(n_valid - base_v), 16'd0);
        check("rstw_temp_kept", temperature, 16'h0000);
        check("rstw_idle", 16'(busy), 16'h0000);

        // Two requests during WAIT merge into one extra measurement
        base_r = rise_cyc.size();
        base_v = n_valid;
        req();
        wait_fall("merge_f1");
        tick();
        req();
        tick();
        req();
        repeat (5) tick();
        man_temp = 16'h0200;
        man_done = 1'b1;
        tick();
        check("merge_idle", 16'(busy), 16'h0000);
        man_done = 1'b0;
        tick();
        check("merge_b2b_start", 16'(sensor_start), 16'h0001);
        wait_fall("merge_f2");
        repeat (5) tick();
        man_temp = 16'h0201;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (150) tick();
        check("merge_pulses", 16'(rise_cyc.size() - base_r), 16'd2);
        check("merge_valids", 16'(n_valid - base_v), 16'd2);
        check("merge_temp", temperature, 16'h0201);
        check("merge_alarm", 16'(alarm), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
